// File: rtl/jtframe_fmeter_pkg.sv
// Shared types for the jtframe frequency meter.
package jtframe_fmeter_pkg;

  // Meter FSM: wait for lock, let the PLL settle, then alternate gate/report.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSettle  = 2'd1,
    StMeasure = 2'd2,
    StReport  = 2'd3
  } fmeter_state_e;

endpackage

// File: rtl/jtframe_sync_edge.sv
// Two-flop synchroniser for an asynchronous input. With EdgeDet=1 the output is a
// one-cycle pulse on each synchronised rising edge (extra delay flop), otherwise
// it is the synchronised level.
module jtframe_sync_edge #(
  parameter bit EdgeDet = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_out
);

  logic [1:0] r_sync;

  // Two-stage metastability filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b00;
    else        r_sync <= {r_sync[0], i_async};
  end

  if (EdgeDet) begin : g_edge
    logic r_dly;

    // Delayed copy of the synchronised level for rise detection.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_dly <= 1'b0;
      else        r_dly <= r_sync[1];
    end

    assign o_out = r_sync[1] & ~r_dly;
  end else begin : g_level
    assign o_out = r_sync[1];
  end

endmodule

// File: rtl/jtframe_freq_meter.sv
// Frequency meter: counts rising edges of sig_in over a window of GATE clk cycles,
// once the PLL lock has been stable for SETTLE cycles. A full gate period is
// GATE+1 cycles (GATE measuring plus one report cycle); no edge is ever dropped
// between consecutive gates.
// Optional macro JTFRAME_FMETER_TOL_EN: stable compares consecutive counts
// against TOL; without it stable just reflects the absence of overflow.
module jtframe_freq_meter
  import jtframe_fmeter_pkg::*;
#(
  parameter int unsigned GATE   = 48000,
  parameter int unsigned CW     = 16,
  parameter int unsigned SETTLE = 1024,
  parameter int unsigned TOL    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          locked,
  input  logic          sig_in,
  output logic [CW-1:0] freq,
  output logic          freq_valid,
  output logic          ovf,
  output logic          stable
);

  localparam int unsigned   GW         = $clog2(GATE);
  localparam int unsigned   SW         = $clog2(SETTLE + 1);
  localparam logic [GW-1:0] GateLast   = GW'(GATE - 1);
  localparam logic [SW-1:0] SettleLast = SW'(SETTLE - 1);
  localparam logic [CW-1:0] CntMax     = {CW{1'b1}};

  fmeter_state_e r_state, w_state_next;
  logic [SW-1:0] r_settle_cnt;
  logic [GW-1:0] r_gate_cnt;
  logic [CW-1:0] r_edge_cnt, w_cnt_inc;
  logic          r_sat, w_sat_inc;
  logic [CW-1:0] r_freq;
  logic          r_ovf, r_stable;
  logic          w_locked, w_edge, w_report_load, w_stable_new;

  jtframe_sync_edge #(.EdgeDet(1'b0)) u_sync_locked (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(locked),
    .o_out  (w_locked)
  );

  jtframe_sync_edge #(.EdgeDet(1'b1)) u_sync_sig (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(sig_in),
    .o_out  (w_edge)
  );

  // Edge count including this cycle's edge. Saturates at CntMax; the sat flag is
  // raised only by an edge that could not be counted.
  always_comb begin
    w_cnt_inc = r_edge_cnt;
    w_sat_inc = r_sat;
    if (w_edge) begin
      if (r_edge_cnt == CntMax) w_sat_inc = 1'b1;
      else                      w_cnt_inc = r_edge_cnt + 1'b1;
    end
  end

  // Next-state logic; losing lock aborts from any state.
  always_comb begin
    w_state_next = r_state;
    if (!w_locked) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle:    w_state_next = StSettle;
        StSettle:  if (r_settle_cnt == SettleLast) w_state_next = StMeasure;
        StMeasure: if (r_gate_cnt == GateLast) w_state_next = StReport;
        StReport:  w_state_next = StMeasure;
        default:   w_state_next = StIdle;
      endcase
    end
  end

  // Results are latched on the last measuring edge so they are valid during REPORT.
  assign w_report_load = (r_state == StMeasure) && (w_state_next == StReport);

`ifdef JTFRAME_FMETER_TOL_EN
  logic          r_have_prev;
  logic [CW-1:0] w_diff;

  // Stability: |new - previous| within TOL, neither gate overflowed, and a
  // previous sample exists since the last lock.
  always_comb begin
    w_diff       = (w_cnt_inc >= r_freq) ? (w_cnt_inc - r_freq) : (r_freq - w_cnt_inc);
    w_stable_new = r_have_prev && !w_sat_inc && !r_ovf && (w_diff <= CW'(TOL));
  end

  // Tracks whether r_freq holds a sample from the current lock period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_have_prev <= 1'b0;
    else if (!w_locked)     r_have_prev <= 1'b0;
    else if (w_report_load) r_have_prev <= 1'b1;
  end
`else
  assign w_stable_new = !w_sat_inc;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // Settle, gate and edge counters; REPORT seeds the next gate with its own edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle_cnt <= '0;
      r_gate_cnt   <= '0;
      r_edge_cnt   <= '0;
      r_sat        <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_settle_cnt <= '0;
          r_gate_cnt   <= '0;
          r_edge_cnt   <= '0;
          r_sat        <= 1'b0;
        end
        StSettle: begin
          r_settle_cnt <= r_settle_cnt + 1'b1;
          r_gate_cnt   <= '0;
          r_edge_cnt   <= '0;
          r_sat        <= 1'b0;
        end
        StMeasure: begin
          r_gate_cnt <= r_gate_cnt + 1'b1;
          r_edge_cnt <= w_cnt_inc;
          r_sat      <= w_sat_inc;
        end
        StReport: begin
          r_gate_cnt <= '0;
          r_edge_cnt <= CW'(w_edge);
          r_sat      <= 1'b0;
        end
        default: begin
          r_settle_cnt <= '0;
          r_gate_cnt   <= '0;
          r_edge_cnt   <= '0;
          r_sat        <= 1'b0;
        end
      endcase
    end
  end

  // Result registers: updated per report, held across lock loss (stable drops).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_freq   <= '0;
      r_ovf    <= 1'b0;
      r_stable <= 1'b0;
    end else if (w_report_load) begin
      r_freq   <= w_cnt_inc;
      r_ovf    <= w_sat_inc;
      r_stable <= w_stable_new;
    end else if (!w_locked) begin
      r_stable <= 1'b0;
    end
  end

  assign freq       = r_freq;
  assign ovf        = r_ovf;
  assign stable     = r_stable;
  assign freq_valid = (r_state == StReport);

endmodule

// File: tb/tb_jtframe_freq_meter.sv
// Scoreboard bench for jtframe_freq_meter. sig_in pulses are placed in bursts well
// inside each predicted gate window, so every gate has a hand-chosen edge count;
// a few extra pulses land exactly on the last measuring cycle and on the report
// cycle. Expected reports (cycle, freq, ovf, stable) are queued when scheduled
// and popped by a monitor on every freq_valid.
module tb_jtframe_freq_meter;

  localparam int unsigned GATE     = 59;
  localparam int unsigned CW       = 4;
  localparam int unsigned SETTLE   = 8;
  localparam int unsigned TOL      = 2;
  localparam int unsigned PER      = GATE + 1;
  localparam int unsigned LOCK2REP = 2 + SETTLE + GATE + 1;  // lock sync + first report
  localparam int unsigned CNT_MAX  = (1 << CW) - 1;
  localparam int unsigned MAP_LEN  = 2048;

`ifdef JTFRAME_FMETER_TOL_EN
  localparam bit TolEn = 1'b1;
`else
  localparam bit TolEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          locked = 1'b0;
  logic          sig_in;
  logic [CW-1:0] freq;
  logic          freq_valid, ovf, stable;

  jtframe_freq_meter #(
    .GATE  (GATE),
    .CW    (CW),
    .SETTLE(SETTLE),
    .TOL   (TOL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .locked    (locked),
    .sig_in    (sig_in),
    .freq      (freq),
    .freq_valid(freq_valid),
    .ovf       (ovf),
    .stable    (stable)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    int unsigned freq;
    int unsigned ovf;
    int unsigned stable;
  } exp_t;

  exp_t        exp_q[$];
  bit          pulse_map[MAP_LEN];
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_reports = 0;
  int unsigned r_a, r_b;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Schedule the pulses of the gate reported at cycle r and optionally queue its
  // expected report. tail: pulse counted on the last measuring edge; head: pulse
  // counted on the previous report cycle.
  task automatic add_gate(input int unsigned r, input int unsigned total, input bit tail,
                          input bit head, input bit st_tol, input bit st_plain,
                          input bit push);
    int unsigned burst;
    exp_t e;
    burst = total - int'(tail) - int'(head);
    for (int i = 0; i < int'(burst); i++) pulse_map[r - GATE + 5 + 3 * i] = 1'b1;
    if (tail) pulse_map[r - 3] = 1'b1;
    if (head) pulse_map[r - PER - 2] = 1'b1;
    if (push) begin
      e.cyc    = r;
      e.freq   = (total > CNT_MAX) ? CNT_MAX : total;
      e.ovf    = (total > CNT_MAX) ? 1 : 0;
      e.stable = TolEn ? st_tol : st_plain;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int unsigned t);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < t);
  endtask

  // sig_in driver: one-cycle pulses from the schedule.
  initial begin
    sig_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sig_in = (cyc < MAP_LEN) ? pulse_map[cyc] : 1'b0;
    end
  end

  // Monitor: every freq_valid must match the oldest queued report.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && freq_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_report: got freq_valid=1 freq=%0d at cycle %0d, expected none",
                   freq, cyc);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("rep%0d_cycle", n_reports), cyc, e.cyc);
          check($sformatf("rep%0d_freq", n_reports), freq, e.freq);
          check($sformatf("rep%0d_ovf", n_reports), ovf, e.ovf);
          check($sformatf("rep%0d_stable", n_reports), stable, e.stable);
        end
        n_reports++;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_freq", freq, 0);
    check("reset_freq_valid", freq_valid, 0);
    check("reset_ovf", ovf, 0);
    check("reset_stable", stable, 0);
    rst_n = 1'b1;
    wait_cyc(cyc + 5);

    // Lock; gates: steady, tail edge, head edge into overflow, exact max, rate jumps.
    r_a = cyc + LOCK2REP;
    add_gate(r_a + 0 * PER, 12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    add_gate(r_a + 1 * PER, 12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    add_gate(r_a + 2 * PER, 13, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    add_gate(r_a + 3 * PER, 16, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    add_gate(r_a + 4 * PER, 15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    add_gate(r_a + 5 * PER, 9,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    add_gate(r_a + 6 * PER, 9,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    add_gate(r_a + 7 * PER, 11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    add_gate(r_a + 8 * PER, 14, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    add_gate(r_a + 9 * PER, 5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    locked = 1'b1;

    // Lose lock mid-gate: no report, last result held, stable cleared.
    wait_cyc(r_a + 8 * PER + 30);
    locked = 1'b0;
    wait_cyc(r_a + 8 * PER + 70);
    check("drop_freq_hold", freq, 14);
    check("drop_ovf_hold", ovf, 0);
    check("drop_stable", stable, 0);

    // Relock: first report again after the full settle + gate latency.
    wait_cyc(r_a + 8 * PER + 100);
    r_b = cyc + LOCK2REP;
    add_gate(r_b + 0 * PER, 10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    add_gate(r_b + 1 * PER, 10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    add_gate(r_b + 2 * PER, 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    locked = 1'b1;

    // Asynchronous reset mid-gate, checked before any further clock edge.
    wait_cyc(r_b + 1 * PER + 30);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_freq", freq, 0);
    check("async_rst_freq_valid", freq_valid, 0);
    check("async_rst_ovf", ovf, 0);
    check("async_rst_stable", stable, 0);

    check("pending_reports", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
